// File: rtl/encoder_16to4_using_enable.sv
// Registered 16-to-4 encoder with enable, selectable multi-hot priority and
// an optional sticky multi-hot error flag.
module encoder_16to4_using_enable #(
  parameter bit PRIORITY_HIGH = 1'b1,
  parameter bit ERR_STICKY    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  o,
  input  logic [15:0] d,
  input  logic        en,
  output logic        valid,
  output logic        err
);

  // valid has no ready partner: when valid=1, o carries the index encoded from
  // the d/en sampled on the previous edge; when valid=0, o is 0 and meaningless.
  logic [3:0] idx;
  logic       any_set;
  logic       multi_set;

  always_comb begin
    idx = 4'd0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 16; i++) begin
        if (d[i]) idx = 4'(i);
      end
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (d[i]) idx = 4'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any_set   = |d;
  assign multi_set = |(d & (d - 16'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o     <= 4'd0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      o     <= en ? idx : 4'd0;
      valid <= en & any_set;
      if (ERR_STICKY) err <= err | (en & multi_set);
      else            err <= en & multi_set;
    end
  end

endmodule

// File: tb/tb_encoder_16to4_using_enable.sv
// Directed bench for encoder_16to4_using_enable: default instance plus a
// low-priority / sticky-error instance, checked through an expected queue.
module tb_encoder_16to4_using_enable;

  logic        clk;
  logic        rst_n;
  logic [15:0] d;
  logic        en;
  logic [3:0]  o_a, o_b;
  logic        valid_a, valid_b, err_a, err_b;

  logic [11:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  encoder_16to4_using_enable dut_a (
    .clk(clk), .rst_n(rst_n), .o(o_a), .d(d), .en(en), .valid(valid_a), .err(err_a)
  );

  encoder_16to4_using_enable #(.PRIORITY_HIGH(1'b0), .ERR_STICKY(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .o(o_b), .d(d), .en(en), .valid(valid_b), .err(err_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one input set on the falling edge, queue the expected result
  task automatic step(input logic r, input logic e, input logic [15:0] dv,
                      input logic [3:0] oa, input logic va, input logic ea,
                      input logic [3:0] ob, input logic vb, input logic eb);
    @(negedge clk);
    rst_n = r;
    en    = e;
    d     = dv;
    exp_q.push_back({oa, va, ea, ob, vb, eb});
  endtask

  // monitor / scoreboard
  initial begin
    logic [11:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {o_a, valid_a, err_a, o_b, valid_b, err_b};
        total++;
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL cmp%0d: a(o,v,e)=%0d,%b,%b b(o,v,e)=%0d,%b,%b required a=%0d,%b,%b b=%0d,%b,%b",
                   total, act_v[11:8], act_v[7], act_v[6], act_v[5:2], act_v[1], act_v[0],
                   exp_v[11:8], exp_v[7], exp_v[6], exp_v[5:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    d     = 16'hffff;

    // reset overrides en/d
    step(0, 1, 16'hffff, 0, 0, 0, 0, 0, 0);
    step(0, 1, 16'h8001, 0, 0, 0, 0, 0, 0);

    // disabled: every one-hot yields zero
    for (int k = 0; k < 16; k++) step(1, 0, 16'(1 << k), 0, 0, 0, 0, 0, 0);

    // enabled one-hot: index k on both instances
    for (int k = 0; k < 16; k++) step(1, 1, 16'(1 << k), 4'(k), 1, 0, 4'(k), 1, 0);

    // empty input
    step(1, 1, 16'h0000, 0, 0, 0, 0, 0, 0);

    // multi-hot: high priority picks 15, low priority picks 0; b err now sticky
    step(1, 1, 16'h8001, 15, 1, 1, 0, 1, 1);
    step(1, 1, 16'h0003, 1, 1, 1, 0, 1, 1);
    step(1, 1, 16'h0004, 2, 1, 0, 2, 1, 1);
    step(1, 1, 16'h0000, 0, 0, 0, 0, 0, 1);

    // enable 1 -> 0 with d=0x2000
    step(1, 1, 16'h2000, 13, 1, 0, 13, 1, 1);
    step(1, 0, 16'h2000, 0, 0, 0, 0, 0, 1);

    // mid-stream reset, then immediate re-encode on release
    step(1, 1, 16'h0400, 10, 1, 0, 10, 1, 1);
    step(0, 1, 16'h0400, 0, 0, 0, 0, 0, 0);
    step(1, 1, 16'h0400, 10, 1, 0, 10, 1, 0);

    // scattered multi-hot (bits 4,6,9,11), then disable keeps only sticky err
    step(1, 1, 16'h0a50, 11, 1, 1, 4, 1, 1);
    step(1, 0, 16'h0a50, 0, 0, 0, 0, 0, 1);
    step(1, 0, 16'hffff, 0, 0, 0, 0, 0, 1);
    step(0, 0, 16'hffff, 0, 0, 0, 0, 0, 0);
    step(1, 1, 16'h0002, 1, 1, 0, 1, 1, 0);

    // drain with a bounded wait
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_16to4_using_enable.md
ENCODER_16TO4_USING_ENABLE -- requirements
Module: encoder_16to4_using_enable

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-low, with ports named clk and rst_n.
REQ-002 Parameter PRIORITY_HIGH, default 1: when 1, the highest set index of d wins on multi-hot input; when 0, the lowest set index wins.
REQ-003 Parameter ERR_STICKY, default 0: when 1, err SHALL hold at 1 until reset; when 0, err is a per-cycle flag.
REQ-004 The port declaration order SHALL be clk, rst_n, o, d, en, valid, err.
REQ-005 Port clk: input, 1 bit, rising-edge clock.
REQ-006 Port rst_n: input, 1 bit, synchronous active-low reset.
REQ-007 Port o: output, 4 bits, registered binary index of the active d bit.
REQ-008 Port d: input, 16 bits, request lines; one-hot expected.
REQ-009 Port en: input, 1 bit, encoder enable, active-high.
REQ-010 Port valid: output, 1 bit, registered; o holds a meaningful index.
REQ-011 Port err: output, 1 bit, registered; d had more than one bit set while en=1.

Function
REQ-012 All outputs SHALL be registered on the rising edge of clk, with a latency of exactly one cycle from d/en to o/valid/err.
REQ-013 When en=1 and d has exactly one bit k set, the next edge SHALL load o=k, valid=1 and err=0 (non-sticky mode).
REQ-014 When en=1 and d=16'h0000, the next edge SHALL load o=0, valid=0 and err=0 (non-sticky mode).
REQ-015 When en=1 and d has two or more bits set, the next edge SHALL load o=the winning index per PRIORITY_HIGH, valid=1 and err=1.
REQ-016 When en=0, the next edge SHALL load o=0, valid=0 and err=0 regardless of d; in sticky mode err SHALL instead hold its value.
REQ-017 The encoding SHALL be purely index-based: d[0]->0, d[1]->1, ..., d[15]->15, with no wrap or saturation.
REQ-018 Inputs SHALL be sampled only at the clock edge; glitches between edges SHALL have no effect.
REQ-019 The outputs SHALL follow input changes on every cycle, with no hold or debounce.

Reset
REQ-020 When rst_n=0 at a rising edge, the block SHALL load o=0, valid=0 and err=0, and reset SHALL override en and d.
REQ-021 If rst_n is asserted mid-stream, the outputs SHALL be cleared at that edge, and the first edge with rst_n=1 SHALL encode the inputs present at that edge.
REQ-022 Sticky err SHALL be cleared only by reset.

Verification
REQ-023 Reset, then en=0 with d stepped through 16'h0001..16'h8000 -> o=0 and valid=0 for every step.
REQ-024 en=1 with d=1<<k for k=0..15 -> one cycle later o=k, valid=1 and err=0 for every k.
REQ-025 en=1 with d=16'h0000 -> o=0 and valid=0; with d=16'h8001 and PRIORITY_HIGH=1 -> o=15, valid=1 and err=1; with PRIORITY_HIGH=0 -> o=0, valid=1 and err=1.
REQ-026 en=1 with d=16'h0400, then rst_n=0 for one cycle -> o=10 first, then o=0 and valid=0 at the reset edge, then o=10 again one cycle after release.
REQ-027 ERR_STICKY=1 with d=16'h0003, then d=16'h0004 -> err=1 persists while o=2 and valid=1, and err clears only after rst_n=0.
REQ-028 en toggled 1->0 with d=16'h2000 -> o=13 and valid=1, then o=0 and valid=0 on the following cycle.
